instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//   Upstream feeder for the RISC-V decode/ALU top. Captures a program streamed in
//   as 32-bit words into a local instruction buffer. A zero word terminates the
//   load. Then replays the buffer in order to the decoder over a valid/ready
//   handshake and flags completion. Replaces the ad-hoc RAM fill in front of decode.
// PARAMETERS
//   WIDTH  32  instruction/data word width
//   DEPTH  32  instruction buffer entries; AW = $clog2(DEPTH) (localparam)
// PORTS
//   clk          in   1      single clock; all state on posedge clk
//   rst          in   1      reset, asynchronous, active-low (0 = reset)
//   load_valid   in   1      load_data valid this cycle
//   load_data    in   WIDTH  program word; 0 = end-of-program marker
//   load_ready   out  1      unit accepts load words (IDLE or LOAD)
//   instr        out  WIDTH  instruction to decoder, registered
//   instr_pc     out  AW     buffer index of instr
//   instr_valid  out  1      instr valid
//   instr_ready  in   1      decoder accepts instr
//   prog_len     out  AW+1   words stored in the current program
//   done         out  1      all stored words delivered
//   overflow     out  1      sticky: nonzero word dropped because buffer full
//   flush        in   1      synchronous abort to IDLE
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, wr_cnt=0, rd_ptr=0. All outputs 0, except
//     load_ready=1 from IDLE. Buffer contents are not reset. Reset mid-load or
//     mid-fetch abandons the program.
//   FSM states: IDLE, LOAD, FETCH, DONE. flush=1 in any state has priority over
//     all other inputs. Next cycle: IDLE; wr_cnt, rd_ptr, prog_len, overflow,
//     done and instr_valid are cleared.
//   IDLE: load_ready=1.
//     - load_valid & load_data!=0: mem[0]<=data, wr_cnt<=1, go to LOAD.
//     - load_valid & load_data==0: ignored; empty program, stay in IDLE.
//   LOAD: load_ready=1.
//     - load_valid & data!=0 & wr_cnt<DEPTH: mem[wr_cnt]<=data, wr_cnt++.
//     - load_valid & data!=0 & wr_cnt==DEPTH: word dropped, overflow<=1 (sticky).
//     - load_valid & data==0: prog_len<=wr_cnt, rd_ptr<=0, go to FETCH.
//       Also the same edge: instr<=mem[0], instr_pc<=0, instr_valid<=1.
//       So the first instr is valid the cycle after the terminator is accepted.
//   FETCH: load_ready=0; load_valid is ignored.
//     - instr, instr_pc stay stable while instr_valid & !instr_ready.
//     - Transfer = instr_valid & instr_ready.
//     - Transfer with rd_ptr+1 < prog_len: rd_ptr++, instr<=mem[rd_ptr+1],
//       instr_valid stays 1. Back-to-back transfers give 1 instr/cycle.
//     - Transfer with rd_ptr+1 == prog_len: instr_valid<=0, done<=1, go to DONE.
//   DONE: done=1, instr_valid=0, load_ready=0. Held until flush or reset.
//     prog_len and overflow stay readable.
//   Width rules:
//     - wr_cnt and prog_len are AW+1 bits, so DEPTH itself is representable.
//     - rd_ptr and instr_pc are AW bits and never wrap: fetch ends at prog_len-1.
//   Buffer: synchronous write, read into the registered instr output. Latency
//     from terminator accept to first instr_valid is 1 cycle.
// TESTING
//   1 Reset: rst=0 mid-FETCH -> outputs 0 immediately, load_ready=1, state IDLE.
//   2 Basic: load 0x00500093, 0x00A08133, 0x002081B3, then 0; instr_ready=1 ->
//     3 instrs on 3 consecutive cycles, pc 0,1,2; then done=1, prog_len=3.
//   3 Backpressure: same program; instr_ready low 4 cycles on pc=1 ->
//     instr=0x00A08133 held stable; no skip, no duplicate.
//   4 Full/overflow: DEPTH=32; load 33 nonzero words, then 0 ->
//     overflow=1, prog_len=32, word 33 never emitted, last pc=31.
//   5 Flush: flush=1 together with instr_ready=1 in FETCH at pc=2 ->
//     IDLE next cycle, instr_valid=0, prog_len=0; a new 1-word load then runs.
//   6 Empty/ignored: 0 in IDLE -> stays IDLE. load_valid in FETCH -> no buffer
//     write, prog_len unchanged.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose
//   Front end for the RISC-V decode/ALU top. A program is streamed in as
//   WIDTH-bit words and captured into a local instruction buffer; a zero word
//   terminates the load. The buffer is then replayed in order to the decoder
//   over a valid/ready handshake, and completion is flagged.
//
// Parameters
//   WIDTH  instruction word width
//   DEPTH  instruction buffer entries (>= 2); AW = $clog2(DEPTH)
//
// Ports
//   clk          in   1      clock, all state on the rising edge
//   rst          in   1      asynchronous reset, active low
//   load_valid   in   1      load_data is valid this cycle
//   load_data    in   WIDTH  program word, zero marks end of program
//   load_ready   out  1      unit accepts load words (IDLE or LOAD)
//   instr        out  WIDTH  registered instruction to the decoder
//   instr_pc     out  AW     buffer index of instr
//   instr_valid  out  1      instr is valid
//   instr_ready  in   1      decoder accepts instr
//   prog_len     out  AW+1   number of words in the current program
//   done         out  1      every stored word has been delivered
//   overflow     out  1      sticky, a nonzero word was dropped (buffer full)
//   flush        in   1      synchronous abort back to IDLE
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic [WIDTH-1:0] instr,
  output logic [AW-1:0]    instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [AW:0]      prog_len,
  output logic             done,
  output logic             overflow,
  input  logic             flush
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FETCH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Write count saturates at DEPTH, which needs the extra bit.
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t          state_reg, state_next;
  logic [AW:0]     wr_cnt_reg, wr_cnt_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW:0]     prog_len_reg, prog_len_next;
  logic            overflow_reg, overflow_next;
  logic            done_reg, done_next;
  logic            instr_valid_reg, instr_valid_next;
  logic [WIDTH-1:0] instr_reg;

  // Instruction buffer (contents are never reset)
  logic [WIDTH-1:0] mem [DEPTH];

  // Buffer port controls
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;

  // -------------------------------------------------------------------------
  // Decoded conditions
  // -------------------------------------------------------------------------
  logic        word_nz;
  logic        word_end;
  logic        xfer;
  logic [AW:0] rd_next_idx;
  logic        more_words;

  assign word_nz     = load_valid && (load_data != '0);
  assign word_end    = load_valid && (load_data == '0);
  assign xfer        = instr_valid_reg && instr_ready;
  // Computed one bit wider so the compare against prog_len cannot wrap.
  assign rd_next_idx = {1'b0, rd_ptr_reg} + ONE_CNT;
  assign more_words  = rd_next_idx < prog_len_reg;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      wr_cnt_reg      <= '0;
      rd_ptr_reg      <= '0;
      prog_len_reg    <= '0;
      overflow_reg    <= 1'b0;
      done_reg        <= 1'b0;
      instr_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wr_cnt_reg      <= wr_cnt_next;
      rd_ptr_reg      <= rd_ptr_next;
      prog_len_reg    <= prog_len_next;
      overflow_reg    <= overflow_next;
      done_reg        <= done_next;
      instr_valid_reg <= instr_valid_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    wr_cnt_next      = wr_cnt_reg;
    rd_ptr_next      = rd_ptr_reg;
    prog_len_next    = prog_len_reg;
    overflow_next    = overflow_reg;
    done_next        = done_reg;
    instr_valid_next = instr_valid_reg;
    mem_we           = 1'b0;
    mem_waddr        = '0;
    rd_en            = 1'b0;
    rd_addr          = '0;

    if (flush) begin
      // Abort wins over every other input, including a pending transfer.
      state_next       = S_IDLE;
      wr_cnt_next      = '0;
      rd_ptr_next      = '0;
      prog_len_next    = '0;
      overflow_next    = 1'b0;
      done_next        = 1'b0;
      instr_valid_next = 1'b0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          // A zero word here would be an empty program: ignore it.
          if (word_nz) begin
            mem_we      = 1'b1;
            mem_waddr   = '0;
            wr_cnt_next = ONE_CNT;
            state_next  = S_LOAD;
          end
        end

        S_LOAD: begin
          if (word_nz) begin
            if (wr_cnt_reg < FULL_CNT) begin
              mem_we      = 1'b1;
              mem_waddr   = wr_cnt_reg[AW-1:0];
              wr_cnt_next = wr_cnt_reg + ONE_CNT;
            end else begin
              overflow_next = 1'b1;
            end
          end else if (word_end) begin
            // Terminator: latch length and prefetch entry 0 on the same edge
            // so the first instruction is valid on the next cycle.
            prog_len_next    = wr_cnt_reg;
            rd_ptr_next      = '0;
            rd_en            = 1'b1;
            rd_addr          = '0;
            instr_valid_next = 1'b1;
            state_next       = S_FETCH;
          end
        end

        S_FETCH: begin
          if (xfer) begin
            if (more_words) begin
              rd_ptr_next = rd_next_idx[AW-1:0];
              rd_en       = 1'b1;
              rd_addr     = rd_next_idx[AW-1:0];
            end else begin
              instr_valid_next = 1'b0;
              done_next        = 1'b1;
              state_next       = S_DONE;
            end
          end
        end

        S_DONE: begin
          // Parked until flush or reset.
        end

        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Instruction buffer: synchronous write, registered read
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= load_data;
    end
  end

  // The read register only advances on a prefetch, so instr holds steady
  // while the decoder stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_reg <= '0;
    end else if (rd_en) begin
      instr_reg <= mem[rd_addr];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign load_ready  = (state_reg == S_IDLE) || (state_reg == S_LOAD);
  assign instr       = instr_reg;
  assign instr_pc    = rd_ptr_reg;
  assign instr_valid = instr_valid_reg;
  assign prog_len    = prog_len_reg;
  assign done        = done_reg;
  assign overflow    = overflow_reg;

endmodule
